// File: rtl/display_7seg_mux.sv
// Display stage: binary count -> BCD via shift-and-add-3, then
// time-multiplexed onto a common-anode 4-digit seven-segment display.
module display_7seg_mux #(
    parameter int TICK_DIV = 2500,
    parameter bit LZB      = 1'b1
) (
    input  logic        clk,
    input  logic        reset_n_i,
    input  logic [7:0]  conta_i,
    output logic [6:0]  segmentos_o,
    output logic [3:0]  anodo_o,
    output logic [11:0] bcd_o,
    output logic        ocupado_o
);

    localparam int TW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [TW-1:0] TICK_MAX = TW'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [7:0]    value_q;
    logic [19:0]   sh_q;
    logic [19:0]   sh_adj;
    logic [3:0]    it_q;
    logic [11:0]   bcd_q;
    logic [TW-1:0] tick_q;
    logic [1:0]    dig_q;
    logic          load;
    logic          shift_en;
    logic          commit;
    logic [3:0]    nib;
    logic [6:0]    seg_raw;
    logic          blank;

    function automatic logic [3:0] add3(input logic [3:0] n);
        return (n >= 4'd5) ? n + 4'd3 : n;
    endfunction

    always_ff @(posedge clk or negedge reset_n_i) begin
        if (!reset_n_i) state <= IDLE;
        else            state <= state_next;
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (conta_i != value_q) state_next = SHIFT;
            SHIFT:   if (it_q == 4'd7) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        load      = (state == IDLE) && (conta_i != value_q);
        shift_en  = (state == SHIFT);
        commit    = (state == DONE);
        ocupado_o = (state != IDLE);
    end

    assign sh_adj = {add3(sh_q[19:16]), add3(sh_q[15:12]),
                     add3(sh_q[11:8]), sh_q[7:0]};

    always_ff @(posedge clk or negedge reset_n_i) begin
        if (!reset_n_i) begin
            value_q <= 8'd0;
            sh_q    <= 20'd0;
            it_q    <= 4'd0;
            bcd_q   <= 12'd0;
        end else begin
            if (load) begin
                value_q <= conta_i;
                sh_q    <= {12'd0, conta_i};
                it_q    <= 4'd0;
            end
            if (shift_en) begin
                sh_q <= {sh_adj[18:0], 1'b0};
                it_q <= it_q + 4'd1;
            end
            if (commit) bcd_q <= sh_q[19:8];
        end
    end

    // Scan runs free of the converter so the display never stalls.
    always_ff @(posedge clk or negedge reset_n_i) begin
        if (!reset_n_i) begin
            tick_q <= '0;
            dig_q  <= 2'd0;
        end else if (tick_q == TICK_MAX) begin
            tick_q <= '0;
            dig_q  <= (dig_q == 2'd2) ? 2'd0 : dig_q + 2'd1;
        end else begin
            tick_q <= tick_q + 1'b1;
        end
    end

    always_comb begin
        nib = bcd_q[3:0];
        unique case (dig_q)
            2'd1:    nib = bcd_q[7:4];
            2'd2:    nib = bcd_q[11:8];
            default: nib = bcd_q[3:0];
        endcase
    end

    always_comb begin
        seg_raw = 7'b1111111;
        unique case (nib)
            4'd0:    seg_raw = 7'b1000000;
            4'd1:    seg_raw = 7'b1111001;
            4'd2:    seg_raw = 7'b0100100;
            4'd3:    seg_raw = 7'b0110000;
            4'd4:    seg_raw = 7'b0011001;
            4'd5:    seg_raw = 7'b0010010;
            4'd6:    seg_raw = 7'b0000010;
            4'd7:    seg_raw = 7'b1111000;
            4'd8:    seg_raw = 7'b0000000;
            4'd9:    seg_raw = 7'b0010000;
            default: seg_raw = 7'b1111111;
        endcase
    end

    // Tens blanks only when hundreds is also zero; ones is always lit.
    always_comb begin
        blank = 1'b0;
        if (LZB) begin
            if (dig_q == 2'd2 && bcd_q[11:8] == 4'd0)
                blank = 1'b1;
            if (dig_q == 2'd1 && bcd_q[11:4] == 8'd0)
                blank = 1'b1;
        end
    end

    assign segmentos_o = blank ? 7'b1111111 : seg_raw;
    assign anodo_o     = {1'b1, ~(3'b001 << dig_q)};
    assign bcd_o       = bcd_q;

endmodule

// File: tb/tb_display_7seg_mux.sv
// Directed bench for display_7seg_mux with a short scan period
// so several full frames fit in each scenario.
module tb_display_7seg_mux;

    logic        clk;
    logic        reset_n_i;
    logic [7:0]  conta_i;
    logic [6:0]  segmentos_o;
    logic [3:0]  anodo_o;
    logic [11:0] bcd_o;
    logic        ocupado_o;

    int total;
    int bad;

    localparam logic [6:0] S0 = 7'b1000000;
    localparam logic [6:0] S1 = 7'b1111001;
    localparam logic [6:0] S2 = 7'b0100100;
    localparam logic [6:0] S5 = 7'b0010010;
    localparam logic [6:0] S7 = 7'b1111000;
    localparam logic [6:0] SB = 7'b1111111;

    display_7seg_mux #(.TICK_DIV(4), .LZB(1'b1)) dut (
        .clk         (clk),
        .reset_n_i   (reset_n_i),
        .conta_i     (conta_i),
        .segmentos_o (segmentos_o),
        .anodo_o     (anodo_o),
        .bcd_o       (bcd_o),
        .ocupado_o   (ocupado_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        conta_i   = 8'd0;
        reset_n_i = 1'b0;
        #12;
        total++;
        if (anodo_o !== 4'b1110 || segmentos_o !== S0) begin
            bad++;
            $display("FAIL reset_disp: got an=%b seg=%b want an=1110 seg=%b",
                     anodo_o, segmentos_o, S0);
        end
        total++;
        if (bcd_o !== 12'h000 || ocupado_o !== 1'b0) begin
            bad++;
            $display("FAIL reset_regs: got bcd=%h busy=%b want 000/0",
                     bcd_o, ocupado_o);
        end
        @(negedge clk);
        reset_n_i = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            total++;
            if (ocupado_o !== 1'b0 || bcd_o !== 12'h000) begin
                bad++;
                $display("FAIL zero_idle: got busy=%b bcd=%h want 0/000",
                         ocupado_o, bcd_o);
            end
            total++;
            if ((anodo_o == 4'b1110 && segmentos_o !== S0) ||
                (anodo_o != 4'b1110 && segmentos_o !== SB)) begin
                bad++;
                $display("FAIL zero_slot: an=%b got seg=%b", anodo_o,
                         segmentos_o);
            end
        end
    endtask

    task automatic test_255();
        int busy;
        busy = 0;
        @(negedge clk);
        conta_i = 8'd255;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (ocupado_o === 1'b1) busy++;
        end
        total++;
        if (busy != 9) begin
            bad++;
            $display("FAIL busy_len: got %0d cycles want 9", busy);
        end
        total++;
        if (bcd_o !== 12'h255) begin
            bad++;
            $display("FAIL bcd_255: got %h want 255", bcd_o);
        end
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            total++;
            if (anodo_o[3] !== 1'b1 ||
                (anodo_o == 4'b1110 && segmentos_o !== S5) ||
                (anodo_o == 4'b1101 && segmentos_o !== S5) ||
                (anodo_o == 4'b1011 && segmentos_o !== S2)) begin
                bad++;
                $display("FAIL disp_255: an=%b got seg=%b", anodo_o,
                         segmentos_o);
            end
        end
    endtask

    task automatic test_7_100();
        @(negedge clk);
        conta_i = 8'd7;
        repeat (12) @(negedge clk);
        total++;
        if (bcd_o !== 12'h007) begin
            bad++;
            $display("FAIL bcd_7: got %h want 007", bcd_o);
        end
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            total++;
            if ((anodo_o == 4'b1110 && segmentos_o !== S7) ||
                (anodo_o != 4'b1110 && segmentos_o !== SB)) begin
                bad++;
                $display("FAIL disp_7: an=%b got seg=%b", anodo_o,
                         segmentos_o);
            end
        end
        conta_i = 8'd100;
        repeat (12) @(negedge clk);
        total++;
        if (bcd_o !== 12'h100) begin
            bad++;
            $display("FAIL bcd_100: got %h want 100", bcd_o);
        end
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            total++;
            if ((anodo_o == 4'b1110 && segmentos_o !== S0) ||
                (anodo_o == 4'b1101 && segmentos_o !== S0) ||
                (anodo_o == 4'b1011 && segmentos_o !== S1)) begin
                bad++;
                $display("FAIL disp_100: an=%b got seg=%b", anodo_o,
                         segmentos_o);
            end
        end
    endtask

    task automatic test_back_to_back();
        bit saw10;
        bit saw11;
        saw10 = 1'b0;
        saw11 = 1'b0;
        @(negedge clk);
        conta_i = 8'd10;
        @(negedge clk);
        conta_i = 8'd11;
        @(negedge clk);
        conta_i = 8'd12;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (bcd_o === 12'h010) saw10 = 1'b1;
            if (bcd_o === 12'h011) saw11 = 1'b1;
        end
        total++;
        if (saw10 !== 1'b1 || saw11 !== 1'b0) begin
            bad++;
            $display("FAIL b2b_seq: got saw010=%b saw011=%b want 1/0",
                     saw10, saw11);
        end
        total++;
        if (bcd_o !== 12'h012) begin
            bad++;
            $display("FAIL b2b_final: got %h want 012", bcd_o);
        end
    endtask

    task automatic test_scan();
        logic [3:0] prev;
        logic [3:0] exp_an;
        int waited;
        waited = 0;
        @(negedge clk);
        prev = anodo_o;
        @(negedge clk);
        while (!(prev != 4'b1110 && anodo_o == 4'b1110) && waited < 40) begin
            prev = anodo_o;
            @(negedge clk);
            waited++;
        end
        total++;
        if (waited >= 40) begin
            bad++;
            $display("FAIL scan_sync: got no slot0 start want one in 40");
        end
        for (int i = 0; i < 24; i++) begin
            exp_an = (i % 12 < 4) ? 4'b1110 :
                     (i % 12 < 8) ? 4'b1101 : 4'b1011;
            total++;
            if (anodo_o !== exp_an) begin
                bad++;
                $display("FAIL scan_seq: cycle %0d got %b want %b", i,
                         anodo_o, exp_an);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        conta_i = 8'd200;
        @(posedge clk);
        repeat (4) @(posedge clk);
        #1;
        reset_n_i = 1'b0;
        #1;
        total++;
        if (anodo_o !== 4'b1110 || segmentos_o !== S0 ||
            bcd_o !== 12'h000 || ocupado_o !== 1'b0) begin
            bad++;
            $display("FAIL mid_reset: got an=%b seg=%b bcd=%h busy=%b",
                     anodo_o, segmentos_o, bcd_o, ocupado_o);
        end
        @(negedge clk);
        reset_n_i = 1'b1;
        @(posedge clk);
        #1;
        total++;
        if (ocupado_o !== 1'b1) begin
            bad++;
            $display("FAIL mid_capture: got busy=%b want 1", ocupado_o);
        end
        repeat (8) @(posedge clk);
        #1;
        total++;
        if (bcd_o !== 12'h000 || ocupado_o !== 1'b1) begin
            bad++;
            $display("FAIL mid_e8: got bcd=%h busy=%b want 000/1",
                     bcd_o, ocupado_o);
        end
        @(posedge clk);
        #1;
        total++;
        if (bcd_o !== 12'h200 || ocupado_o !== 1'b0) begin
            bad++;
            $display("FAIL mid_e9: got bcd=%h busy=%b want 200/0",
                     bcd_o, ocupado_o);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_255();
        test_7_100();
        test_back_to_back();
        test_scan();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
